// File: rtl/sub_pkg.sv
// Shared definitions for the serial subtractor: FSM encoding, slice width,
// and the 16-bit signed saturation limits.
package sub_pkg;

  localparam int SLICE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [15:0] SAT_POS = 16'h7FFF;
  localparam logic [15:0] SAT_NEG = 16'h8000;

endpackage

// File: rtl/add_slice.sv
// W-bit ripple add with carry in/out; the serial subtractor time-multiplexes
// one instance over every slice of the operands.
module add_slice #(
  parameter int W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout
);

  // Single wide add; the top bit of the result is the carry out.
  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};

endmodule

// File: rtl/sub16_serial.sv
// Multi-cycle subtractor Y = A - B - B_in, one SLICE-bit slice per clock,
// LSB slice first. Subtraction is A + ~B + ~B_in through a shared add slice.
// Visible Y/flags only change on the edge entering DONE; the partial result
// accumulates in a shadow register.
// Optional macro SUB16_SAT_EN: signed saturation of Y on overflow.
module sub16_serial
  import sub_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SLICE = SLICE_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             B_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Y,
  output logic             B_out,
  output logic             Z,
  output logic             N,
  output logic             V
);

  localparam int NSL = WIDTH / SLICE;
  localparam int IW  = (NSL > 1) ? $clog2(NSL) : 1;
  localparam logic [IW-1:0] LAST = IW'(NSL - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0] ysh_q, ysh_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic             carry_q, carry_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic             bout_q, bout_d, z_q, z_d, n_q, n_d, v_q, v_d;

  logic [SLICE-1:0] s_a, s_b, s_sum;
  logic             s_cout;
  logic             v_raw;

  // Current slice operands: minuend slice and inverted subtrahend slice.
  assign s_a = a_q[idx_q*SLICE +: SLICE];
  assign s_b = ~b_q[idx_q*SLICE +: SLICE];

  add_slice #(.W(SLICE)) u_slice (
    .a    (s_a),
    .b    (s_b),
    .cin  (carry_q),
    .sum  (s_sum),
    .cout (s_cout)
  );

  // Next-state, slice sequencing and result/flag formation.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    ysh_d   = ysh_q;
    y_d     = y_q;
    carry_d = carry_q;
    idx_d   = idx_q;
    bout_d  = bout_q;
    z_d     = z_q;
    n_d     = n_q;
    v_d     = v_q;
    v_raw   = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (start) begin
          a_d     = A;
          b_d     = B;
          carry_d = ~B_in;   // borrow-in becomes inverted carry-in
          idx_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        ysh_d[idx_q*SLICE +: SLICE] = s_sum;
        carry_d = s_cout;
        idx_d   = idx_q + 1'b1;
        if (idx_q == LAST) begin
          state_d = DONE;
          v_raw   = (a_q[WIDTH-1] != b_q[WIDTH-1]) &&
                    (ysh_d[WIDTH-1] != a_q[WIDTH-1]);
          v_d     = v_raw;
          bout_d  = ~s_cout;
`ifdef SUB16_SAT_EN
          if (v_raw)
            y_d = a_q[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                               : {1'b0, {(WIDTH-1){1'b1}}};
          else
            y_d = ysh_d;
`else
          y_d = ysh_d;
`endif
          z_d = (y_d == '0);
          n_d = y_d[WIDTH-1];
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, operand, shadow and visible-result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      ysh_q   <= '0;
      y_q     <= '0;
      carry_q <= 1'b0;
      idx_q   <= '0;
      bout_q  <= 1'b0;
      z_q     <= 1'b0;
      n_q     <= 1'b0;
      v_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      ysh_q   <= ysh_d;
      y_q     <= y_d;
      carry_q <= carry_d;
      idx_q   <= idx_d;
      bout_q  <= bout_d;
      z_q     <= z_d;
      n_q     <= n_d;
      v_q     <= v_d;
    end
  end

  assign busy  = (state_q == RUN);
  assign done  = (state_q == DONE);
  assign Y     = y_q;
  assign B_out = bout_q;
  assign Z     = z_q;
  assign N     = n_q;
  assign V     = v_q;

endmodule

// File: tb/tb_sub16_serial.sv
// Bench for sub16_serial: arithmetic reference model with a latency queue,
// per-cycle compare, plus directed vectors with literal expectations.
module tb_sub16_serial;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] A, B;
  logic        B_in;
  logic        busy, done, B_out, Z, N, V;
  logic [15:0] Y;

  int errs   = 0;
  int checks = 0;

  sub16_serial dut (
    .clk(clk), .rst(rst), .start(start), .A(A), .B(B), .B_in(B_in),
    .busy(busy), .done(done), .Y(Y), .B_out(B_out), .Z(Z), .N(N), .V(V)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  typedef struct packed {
    logic [15:0] y;
    logic        bo, z, n, v;
  } res_t;

  // Reference result straight from integer arithmetic.
  function automatic res_t ref_sub(input logic [15:0] a, input logic [15:0] b, input logic bin);
    res_t r;
    int   ures, sres;
    ures = int'(a) - int'(b) - int'(bin);
    sres = int'($signed(a)) - int'($signed(b)) - int'(bin);
    r.y  = ures[15:0];
    r.bo = (ures < 0);
    r.v  = (sres > 32767) || (sres < -32768);
`ifdef SUB16_SAT_EN
    if (r.v) r.y = (sres > 0) ? 16'h7FFF : 16'h8000;
`endif
    r.z = (r.y == 16'h0000);
    r.n = r.y[15];
    return r;
  endfunction

  // Model: an accepted op delivers its result 4 edges later.
  int   m_cnt  = 0;
  logic m_done = 1'b0;
  res_t m_res  = '0;
  res_t p_res  = '0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_cnt  <= 0;
      m_done <= 1'b0;
      m_res  <= '0;
      p_res  <= '0;
    end else begin
      m_done <= (m_cnt == 1);
      if (m_cnt != 0) begin
        m_cnt <= m_cnt - 1;
        if (m_cnt == 1) m_res <= p_res;
      end else if (start) begin
        p_res <= ref_sub(A, B, B_in);
        m_cnt <= 4;
      end
    end
  end

  // Per-cycle compare against the model.
  always @(negedge clk) begin
    chk("m_busy", busy, (m_cnt != 0));
    chk("m_done", done, m_done);
    chk("m_result", {Y, B_out, Z, N, V}, m_res);
  end

  // One op: expected result/flags {B_out,Z,N,V}, Y held at prev until done.
  task automatic do_op(input string nm, input logic [15:0] a, input logic [15:0] b,
                       input logic bi, input logic [15:0] prev,
                       input logic [15:0] ey, input logic [3:0] ef);
    int lat;
    @(negedge clk);
    A = a; B = b; B_in = bi; start = 1'b1;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (lat == 1) start = 1'b0;
      if (!done) chk({nm, "_held"}, Y, prev);
    end while (!done && lat < 20);
    chk({nm, "_done"}, done, 1'b1);
    chk({nm, "_lat"}, lat, 5);
    chk({nm, "_y"}, Y, ey);
    chk({nm, "_flags"}, {B_out, Z, N, V}, ef);
  endtask

  initial begin
    int n;
    int seen;
    rst = 1'b1; start = 1'b0; A = '0; B = '0; B_in = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_y", Y, 16'h0000);
    chk("rst_flags", {busy, done, B_out, Z, N, V}, 6'b0);
    rst = 1'b0;

    do_op("basic", 16'h1234, 16'h0234, 1'b0, 16'h0000, 16'h1000, 4'b0000);
    do_op("wrap",  16'h0000, 16'h0001, 1'b0, 16'h1000, 16'hFFFF, 4'b1010);
    do_op("zero",  16'h0005, 16'h0005, 1'b0, 16'hFFFF, 16'h0000, 4'b0100);
    do_op("chain", 16'h1000, 16'h0001, 1'b1, 16'h0000, 16'h0FFE, 4'b0000);
`ifdef SUB16_SAT_EN
    do_op("ovf",   16'h8000, 16'h0001, 1'b0, 16'h0FFE, 16'h8000, 4'b0011);
`else
    do_op("ovf",   16'h8000, 16'h0001, 1'b0, 16'h0FFE, 16'h7FFF, 4'b0001);
`endif

    // start held through RUN with changing operands; back-to-back in DONE.
    @(negedge clk);
    A = 16'h9999; B = 16'h1111; B_in = 1'b0; start = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      A = A + 16'h0101; B = B + 16'h0022;
    end
    @(negedge clk);
    chk("hs_done", done, 1'b1);
    chk("hs_y", Y, 16'h8888);
    A = 16'h0050; B = 16'h0010; start = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (n == 1) start = 1'b0;
    end while (!done && n < 20);
    chk("hs_b2b_gap", n, 5);
    chk("hs_b2b_y", Y, 16'h0040);

    // Asynchronous reset two cycles into an op.
    @(negedge clk);
    A = 16'h1234; B = 16'h0034; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_y", Y, 16'h0000);
    chk("arst_state", {busy, done, B_out, Z, N, V}, 6'b0);
    seen = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (done) seen++;
    end
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (done) seen++;
    end
    chk("arst_no_done", seen, 0);

    do_op("post", 16'h00FF, 16'h000F, 1'b0, 16'h0000, 16'h00F0, 4'b0000);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
